controle_exibicao_sequencia: RTL and testbench
==============================================

CONTROLE_EXIBICAO_SEQUENCIA -- requirements
Module: controle_exibicao_sequencia

Interface
REQ-001 Parameter T_ACESO, default 1000: clock cycles each sequence element is lit on leds (legal range 1..65535).
REQ-002 Parameter T_APAGADO, default 500: clock cycles of dark gap after each element (legal range 1..65535).
REQ-003 clock  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 iniciar  input  1  start request; sampled only in state INICIAL.
REQ-006 cancelar  input  1  abort request; sampled in every state.
REQ-007 limite  input  4  index of the last element to show (round number minus one).
REQ-008 dado_memoria  input  4  sequence memory data at endereco, combinational read.
REQ-009 endereco  output  4  sequence memory address.
REQ-010 leds  output  4  registered LED pattern shown to the player.
REQ-011 exibindo  output  1  high in every state except INICIAL.
REQ-012 pronto  output  1  one-cycle pulse: display of the round completed.
REQ-013 db_estado  output  4  current state encoding, for a hexa7seg display.

Function
REQ-014 The FSM SHALL have states INICIAL=0, PREPARA=1, ACENDE=2, APAGA=3, PROXIMO=4, FIM=5; codes 6..15 unused; any unused code SHALL go to INICIAL on the next edge.
REQ-015 INICIAL with iniciar=1 and cancelar=0 SHALL go to PREPARA; otherwise it stays in INICIAL.
REQ-016 PREPARA SHALL last 1 cycle: endereco←0, limite latched into an internal register, timer loaded with T_ACESO; next state is ACENDE.
REQ-017 ACENDE SHALL last exactly T_ACESO cycles with leds=dado_memoria (registered, valid from the first ACENDE cycle); next state is APAGA with the timer loaded with T_APAGADO.
REQ-018 APAGA SHALL last exactly T_APAGADO cycles with leds=0000; on its last cycle the next state is FIM if endereco equals latched limite, otherwise PROXIMO.
REQ-019 PROXIMO SHALL last 1 cycle: endereco←endereco+1, timer loaded with T_ACESO; next state is ACENDE.
REQ-020 FIM SHALL last 1 cycle with pronto=1 and leds=0000; next state is INICIAL.
REQ-021 Latency: pronto SHALL be high exactly 2+(L+1)·(T_ACESO+T_APAGADO)+L cycles after the edge that sampled iniciar, where L is the latched limite.
REQ-022 Changes on limite after PREPARA SHALL be ignored until the next start.
REQ-023 endereco SHALL never wrap: with L=15 it SHALL stop at 15 and FIM follows.
REQ-024 iniciar outside INICIAL SHALL be ignored; no restart, no effect on endereco or the timer.
REQ-025 cancelar=1 in any state SHALL force INICIAL on the next edge, with leds=0000, endereco=0, and no pronto pulse.
REQ-026 If cancelar and iniciar are both high in INICIAL, cancelar SHALL win and the FSM stays in INICIAL.
REQ-027 leds SHALL be 0000 in every state except ACENDE.
REQ-028 The timer SHALL be a 16-bit down-counter that flags its terminal count on the last cycle of the loaded interval.

Reset
REQ-029 reset=0 at a rising edge SHALL force state INICIAL, endereco=0, leds=0000, latched limite=0, timer=0, pronto=0, exibindo=0, db_estado=0000, whatever the current state (including mid-ACENDE).
REQ-030 reset SHALL take priority over cancelar and iniciar.

Structure
REQ-031 A shared package SHALL hold the state encodings (INICIAL..FIM), the 4-bit state width and the default T_ACESO/T_APAGADO values.
REQ-032 The timer SHALL be a sub-module named contador_tempo (inputs: load, value[15:0], enable; output: fim), instantiated once.

Verification (T_ACESO=4, T_APAGADO=2; memory {0001,0010,0100,1000,…})
REQ-033 limite=2, iniciar pulse -> leds 0001×4, 0000×2, 0000(PROXIMO), 0010×4, 0000×2, 0000, 0100×4, 0000×2; pronto high exactly 22 cycles after the sampling edge, for one cycle.
REQ-034 limite=0 -> a single 0001 for 4 cycles; pronto at cycle 8; endereco stays 0.
REQ-035 limite=15 -> endereco steps 0..15 without wrap; pronto at cycle 113.
REQ-036 cancelar pulse in the 2nd ACENDE cycle of element 1 -> INICIAL next cycle, leds=0000, endereco=0, no pronto; a following iniciar restarts from endereco 0.
REQ-037 iniciar re-pulsed during APAGA, and limite changed from 2 to 5 mid-display -> no effect; pronto still at cycle 22.
REQ-038 reset=0 during ACENDE -> next edge all outputs are at reset values, db_estado=0000; iniciar together with reset=0 is ignored.

Source files
------------

// File: rtl/controle_exibicao_sequencia_pkg.sv
// Shared definitions for the sequence-display controller: state codes,
// state width and default lit/dark durations.
package controle_exibicao_sequencia_pkg;

  localparam int unsigned ST_W = 4;

  localparam logic [ST_W-1:0] INICIAL = 4'd0;
  localparam logic [ST_W-1:0] PREPARA = 4'd1;
  localparam logic [ST_W-1:0] ACENDE  = 4'd2;
  localparam logic [ST_W-1:0] APAGA   = 4'd3;
  localparam logic [ST_W-1:0] PROXIMO = 4'd4;
  localparam logic [ST_W-1:0] FIM     = 4'd5;

  localparam int unsigned T_ACESO_DEF   = 1000;
  localparam int unsigned T_APAGADO_DEF = 500;

endpackage

// File: rtl/controle_exibicao_sequencia_if.sv
// Player-side control and sequence-memory signals of the display controller.
interface controle_exibicao_sequencia_if;
  import controle_exibicao_sequencia_pkg::*;

  logic            iniciar;
  logic            cancelar;
  logic [3:0]      limite;
  logic [3:0]      dado_memoria;
  logic [3:0]      endereco;
  logic [3:0]      leds;
  logic            exibindo;
  logic            pronto;
  logic [ST_W-1:0] db_estado;

  modport master (
    output iniciar, cancelar, limite, dado_memoria,
    input  endereco, leds, exibindo, pronto, db_estado
  );

  modport slave (
    input  iniciar, cancelar, limite, dado_memoria,
    output endereco, leds, exibindo, pronto, db_estado
  );
endinterface

// File: rtl/controle_exibicao_sequencia_contador_tempo.sv
// 16-bit interval down-counter; fim is high on the last cycle of a loaded interval.
module contador_tempo (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        enable,
  output logic        fim
);

  logic [15:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  // A loaded value of N reaches 1 on the N-th enabled cycle.
  assign fim = enable && (r_cnt == 16'd1);

endmodule

// File: rtl/controle_exibicao_sequencia.sv
// Shows memory elements 0..limite on the LEDs, each lit for T_ACESO cycles
// followed by a T_APAGADO dark gap, then pulses pronto.
module controle_exibicao_sequencia
  import controle_exibicao_sequencia_pkg::*;
#(
  parameter int unsigned T_ACESO   = T_ACESO_DEF,
  parameter int unsigned T_APAGADO = T_APAGADO_DEF
) (
  input logic                          clock,
  input logic                          reset,
  controle_exibicao_sequencia_if.slave bus
);

  localparam logic [15:0] W_T_ACESO   = 16'(T_ACESO);
  localparam logic [15:0] W_T_APAGADO = 16'(T_APAGADO);

  logic [ST_W-1:0] r_estado;
  logic [ST_W-1:0] w_prox;
  logic [3:0]      r_endereco;
  logic [3:0]      r_limite;
  logic [3:0]      r_leds;
  logic            w_load;
  logic [15:0]     w_valor;
  logic            w_enable;
  logic            w_fim;

  always_comb begin
    w_prox = r_estado;
    if (bus.cancelar) begin
      w_prox = INICIAL;
    end else begin
      case (r_estado)
        INICIAL: if (bus.iniciar) w_prox = PREPARA;
        PREPARA: w_prox = ACENDE;
        ACENDE:  if (w_fim) w_prox = APAGA;
        APAGA:   if (w_fim) w_prox = (r_endereco == r_limite) ? FIM : PROXIMO;
        PROXIMO: w_prox = ACENDE;
        FIM:     w_prox = INICIAL;
        default: w_prox = INICIAL;
      endcase
    end
  end

  always_comb begin
    w_enable = (r_estado == ACENDE) || (r_estado == APAGA);
    w_load   = !bus.cancelar &&
               ((r_estado == PREPARA) || (r_estado == PROXIMO) ||
                ((r_estado == ACENDE) && w_fim));
    w_valor  = (r_estado == ACENDE) ? W_T_APAGADO : W_T_ACESO;
  end

  contador_tempo u_contador_tempo (
    .clock  (clock),
    .reset  (reset),
    .load   (w_load),
    .value  (w_valor),
    .enable (w_enable),
    .fim    (w_fim)
  );

  // Address moves on the edge entering PREPARA/PROXIMO so the memory word is
  // already settled when the LED register captures it entering ACENDE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado   <= INICIAL;
      r_endereco <= '0;
      r_limite   <= '0;
      r_leds     <= '0;
    end else begin
      r_estado <= w_prox;
      r_leds   <= (w_prox == ACENDE) ? bus.dado_memoria : '0;
      if (bus.cancelar || (w_prox == PREPARA)) begin
        r_endereco <= '0;
      end else if (w_prox == PROXIMO) begin
        r_endereco <= r_endereco + 4'd1;
      end
      if ((r_estado == PREPARA) && !bus.cancelar) begin
        r_limite <= bus.limite;
      end
    end
  end

  assign bus.endereco  = r_endereco;
  assign bus.leds      = r_leds;
  assign bus.exibindo  = (r_estado != INICIAL);
  assign bus.pronto    = (r_estado == FIM);
  assign bus.db_estado = r_estado;

endmodule

// File: tb/tb_controle_exibicao_sequencia.sv
// Directed bench for controle_exibicao_sequencia with a per-cycle expected-output queue.
module tb_controle_exibicao_sequencia;

  localparam int TA = 4;
  localparam int TP = 2;

  typedef struct {
    int st;
    int leds;
    int addr;
    int pronto;
  } exp_t;

  logic clock;
  logic reset;
  controle_exibicao_sequencia_if bus ();

  controle_exibicao_sequencia #(.T_ACESO(TA), .T_APAGADO(TP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] mem [16];
  exp_t q [$];
  int   idle_addr = 0;
  int   cur_st    = 0;
  int   last_len  = 0;
  bit   armed     = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   cyc       = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.dado_memoria = mem[bus.endereco];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One entry per cycle: PREPARA, then per element (PROXIMO,) lit, dark; then FIM.
  task automatic build(input int lim);
    q.delete();
    q.push_back('{st: 1, leds: 0, addr: 0, pronto: 0});
    for (int i = 0; i <= lim; i++) begin
      if (i > 0) q.push_back('{st: 4, leds: 0, addr: i, pronto: 0});
      for (int k = 0; k < TA; k++) q.push_back('{st: 2, leds: int'(mem[i]), addr: i, pronto: 0});
      for (int k = 0; k < TP; k++) q.push_back('{st: 3, leds: 0, addr: i, pronto: 0});
    end
    q.push_back('{st: 5, leds: 0, addr: lim, pronto: 1});
    last_len  = q.size();
    idle_addr = lim;
  endtask

  always @(posedge clock) begin
    if (!reset) begin
      q.delete();
      idle_addr = 0;
      armed = 1;
    end else if (bus.cancelar) begin
      q.delete();
      idle_addr = 0;
    end else if (cur_st == 0 && q.size() == 0 && bus.iniciar) begin
      build(int'(bus.limite));
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (armed) begin
      if (q.size() > 0) e = q.pop_front();
      else e = '{st: 0, leds: 0, addr: idle_addr, pronto: 0};
      cur_st = e.st;
      chk("db_estado", int'(bus.db_estado), e.st);
      chk("leds", int'(bus.leds), e.leds);
      chk("endereco", int'(bus.endereco), e.addr);
      chk("pronto", int'(bus.pronto), e.pronto);
      chk("exibindo", int'(bus.exibindo), (e.st != 0) ? 1 : 0);
    end
  end

  task automatic start(input logic [3:0] lim);
    @(negedge clock);
    bus.limite  = lim;
    bus.iniciar = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.iniciar = 1'b0;
    cyc = 1;
  endtask

  task automatic to_cycle(input int k);
    while (cyc < k) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic wait_pronto(input int exp);
    while (bus.pronto !== 1'b1 && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    chk("pronto_latencia", cyc, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'b0001 << (i % 4);
    reset        = 1'b0;
    bus.iniciar  = 1'b0;
    bus.cancelar = 1'b0;
    bus.limite   = 4'd0;
    idle(3);
    chk("reset_db_estado", int'(bus.db_estado), 0);
    chk("reset_exibindo", int'(bus.exibindo), 0);
    reset = 1'b1;
    idle(2);

    // three elements
    start(4'd2);
    chk("model_len_L2", last_len, 22);
    wait_pronto(22);
    idle(3);

    // single element
    start(4'd0);
    chk("model_len_L0", last_len, 8);
    wait_pronto(8);
    idle(2);

    // full sequence, no address wrap
    start(4'd15);
    chk("model_len_L15", last_len, 113);
    wait_pronto(113);
    chk("endereco_final", int'(bus.endereco), 15);
    idle(2);

    // abort in the second lit cycle of element 1
    start(4'd2);
    to_cycle(10);
    chk("antes_cancel_leds", int'(bus.leds), 2);
    bus.cancelar = 1'b1;
    to_cycle(11);
    bus.cancelar = 1'b0;
    chk("cancel_endereco", int'(bus.endereco), 0);
    chk("cancel_leds", int'(bus.leds), 0);
    chk("cancel_estado", int'(bus.db_estado), 0);
    idle(5);
    start(4'd2);
    to_cycle(2);
    chk("restart_leds", int'(bus.leds), 1);
    chk("restart_endereco", int'(bus.endereco), 0);
    wait_pronto(22);
    idle(2);

    // late iniciar and limite change are ignored
    start(4'd2);
    to_cycle(6);
    bus.iniciar = 1'b1;
    to_cycle(7);
    bus.iniciar = 1'b0;
    to_cycle(10);
    bus.limite = 4'd5;
    wait_pronto(22);
    idle(3);

    // reset mid-ACENDE with iniciar held high
    start(4'd1);
    to_cycle(3);
    reset = 1'b0;
    bus.iniciar = 1'b1;
    to_cycle(4);
    chk("rst_leds", int'(bus.leds), 0);
    chk("rst_endereco", int'(bus.endereco), 0);
    chk("rst_db_estado", int'(bus.db_estado), 0);
    chk("rst_pronto", int'(bus.pronto), 0);
    reset = 1'b1;
    bus.iniciar = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
